// File: rtl/dco_pkg.sv
// Shared types and default widths for the multi-channel DCO.
package dco_pkg;

    // Oscillator operating mode of a channel.
    typedef enum logic {
        DCO_DIV = 1'b0,
        DCO_NCO = 1'b1
    } dco_mode_e;

    localparam int DCO_CHANNELS   = 4;
    localparam int DCO_CODE_W     = 8;
    localparam int DCO_ACC_W      = 16;
    localparam int DCO_RESET_CODE = 1;

    // Width of a channel index. A single channel still gets a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dco_array_if.sv
// Config port of the DCO array: valid/ready request carrying channel, mode and code.
interface dco_array_if
    import dco_pkg::*;
#(
    parameter int CH_W   = 2,
    parameter int CODE_W = DCO_CODE_W
) ();

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    dco_mode_e         cfg_mode;
    logic [CODE_W-1:0] cfg_code;

    // Requester side: drives the request, observes ready.
    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_code,
        input  cfg_ready
    );

    // DCO side: observes the request, drives ready.
    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_code,
        output cfg_ready
    );

endinterface

// File: rtl/dco_channel.sv
// One oscillator (divider or NCO) with its shadow config, pending flag and
// period-boundary apply logic.
module dco_channel
    import dco_pkg::*;
#(
    parameter int CODE_W     = DCO_CODE_W,
    parameter int ACC_W      = DCO_ACC_W,
    parameter int RESET_CODE = DCO_RESET_CODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sync,
    input  logic              sel,       // config request addressed to this channel
    input  dco_mode_e         cfg_mode,
    input  logic [CODE_W-1:0] cfg_code,
    output logic              out,
    output logic              pend
);

    logic [CODE_W-1:0] act_code_q, act_code_d;
    dco_mode_e         act_mode_q, act_mode_d;
    logic [CODE_W-1:0] shd_code_q, shd_code_d;
    dco_mode_e         shd_mode_q, shd_mode_d;
    logic              pend_q,     pend_d;
    logic [CODE_W-1:0] cnt_q,      cnt_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic              out_q,      out_d;

    logic [ACC_W:0]    sum;          // accumulator sum including carry-out
    logic              boundary;

    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - CODE_W){1'b0}}, act_code_q};

    // Next-state: sync realign, else counting with boundary apply, then config accept.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        act_code_d = act_code_q;
        act_mode_d = act_mode_q;
        shd_code_d = shd_code_q;
        shd_mode_d = shd_mode_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_d      = out_q;
        boundary   = 1'b0;

        if (sync) begin
            // Realign: apply any waiting shadow, then restart from the low half.
            if (pend_q) begin
                act_code_d = shd_code_q;
                act_mode_d = shd_mode_q;
                pend_d     = 1'b0;
            end
            cnt_d = pend_q ? shd_code_q : act_code_q;
            acc_d = '0;
            out_d = 1'b0;
        end else if (ena) begin
            if (act_mode_q == DCO_DIV) begin
                if (cnt_q == '0) begin
                    out_d    = ~out_q;
                    cnt_d    = act_code_q;
                    boundary = ~out_q;        // only the rising toggle starts a period
                end else begin
                    cnt_d = cnt_q - CODE_W'(1);
                end
            end else begin
                acc_d    = sum[ACC_W-1:0];
                out_d    = sum[ACC_W-1];
                boundary = sum[ACC_W] || (act_code_q == '0);
            end

            if (boundary && pend_q) begin
                act_code_d = shd_code_q;
                act_mode_d = shd_mode_q;
                pend_d     = 1'b0;
                if (shd_mode_q == DCO_DIV) begin
                    // The toggle still happens, so the new period starts high.
                    cnt_d = shd_code_q;
                    out_d = 1'b1;
                end else begin
                    acc_d = '0;
                    out_d = 1'b0;
                end
            end
        end

        // Accept needs pend=0 and apply needs pend=1, so the two never collide.
        if (sel && !pend_q) begin
            shd_code_d = cfg_code;
            shd_mode_d = cfg_mode;
            pend_d     = 1'b1;
        end
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_code_q <= CODE_W'(RESET_CODE);
            act_mode_q <= DCO_DIV;
            shd_code_q <= '0;
            shd_mode_q <= DCO_DIV;
            pend_q     <= 1'b0;
            cnt_q      <= CODE_W'(RESET_CODE);
            acc_q      <= '0;
            out_q      <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all flops sample together.
            act_code_q <= act_code_d;
            act_mode_q <= act_mode_d;
            shd_code_q <= shd_code_d;
            shd_mode_q <= shd_mode_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
        end
    end

    assign out  = out_q;
    assign pend = pend_q;

endmodule

// File: rtl/dco_array.sv
// Multi-channel DCO: config decode, ready mux and sync fan-out around
// CHANNELS independent dco_channel instances.
module dco_array
    import dco_pkg::*;
#(
    parameter int CHANNELS   = DCO_CHANNELS,
    parameter int CODE_W     = DCO_CODE_W,
    parameter int ACC_W      = DCO_ACC_W,
    parameter int RESET_CODE = DCO_RESET_CODE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                sync,
    dco_array_if.slave          cfg,
    output logic [CHANNELS-1:0] dco_out,
    output logic [CHANNELS-1:0] pending
);

    localparam int CH_W = ch_width(CHANNELS);

    logic [CHANNELS-1:0] sel;
    logic                cfg_ready_c;

    // Decode the request to one channel; out-of-range indices select nothing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel[i] = cfg.cfg_valid && (cfg.cfg_ch == CH_W'(i));
        end
    end

    // Ready mux: a pending channel stalls; an out-of-range index is always ready.
    always_comb begin
        cfg_ready_c = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfg_ready_c = ~pending[i];
            end
        end
    end

    assign cfg.cfg_ready = cfg_ready_c;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        dco_channel #(
            .CODE_W     (CODE_W),
            .ACC_W      (ACC_W),
            .RESET_CODE (RESET_CODE)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .sync     (sync),
            .sel      (sel[g]),
            .cfg_mode (cfg.cfg_mode),
            .cfg_code (cfg.cfg_code),
            .out      (dco_out[g]),
            .pend     (pending[g])
        );
    end

endmodule

// File: tb/tb_dco_array.sv
// Self-checking bench for dco_array: a phase/period model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dco_array;
    import dco_pkg::*;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int AW   = 16;
    localparam int RC   = 1;
    localparam int MOD  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          sync = 1'b0;
    logic [CH-1:0] dco_out;
    logic [CH-1:0] pending;

    int checks = 0;
    int errors = 0;

    dco_array_if #(.CH_W(2), .CODE_W(CW)) cfg_if ();

    dco_array #(
        .CHANNELS   (CH),
        .CODE_W     (CW),
        .ACC_W      (AW),
        .RESET_CODE (RC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .sync    (sync),
        .cfg     (cfg_if.slave),
        .dco_out (dco_out),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // DIV channels are tracked as a phase t within a 2(code+1) period whose
    // first code+1 cycles are high; NCO channels as a plain modular accumulator.
    bit m_mode [CH];
    int m_code [CH];
    int m_t    [CH];
    int m_acc  [CH];
    bit m_nout [CH];
    bit m_smode[CH];
    int m_scode[CH];
    bit m_pend [CH];

    function automatic bit m_out(input int i);
        return m_mode[i] ? m_nout[i] : (m_t[i] <= m_code[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_mode[i] = 1'b0; m_code[i] = RC; m_t[i] = RC + 1;
                m_acc[i] = 0; m_nout[i] = 1'b0;
                m_smode[i] = 1'b0; m_scode[i] = 0; m_pend[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                bit take, bnd;
                int s;
                take = cfg_if.cfg_valid && (int'(cfg_if.cfg_ch) == i) && !m_pend[i];
                bnd  = 1'b0;
                if (sync) begin
                    if (m_pend[i]) begin
                        m_mode[i] = m_smode[i]; m_code[i] = m_scode[i]; m_pend[i] = 1'b0;
                    end
                    m_t[i] = m_code[i] + 1;
                    m_acc[i] = 0; m_nout[i] = 1'b0;
                end else if (ena) begin
                    if (!m_mode[i]) begin
                        m_t[i]++;
                        if (m_t[i] == 2 * (m_code[i] + 1)) begin
                            m_t[i] = 0; bnd = 1'b1;
                        end
                    end else begin
                        s = m_acc[i] + m_code[i];
                        bnd = (s >= MOD) || (m_code[i] == 0);
                        m_acc[i] = s % MOD;
                        m_nout[i] = (m_acc[i] >= MOD / 2);
                    end
                    if (bnd && m_pend[i]) begin
                        m_mode[i] = m_smode[i]; m_code[i] = m_scode[i]; m_pend[i] = 1'b0;
                        if (!m_mode[i]) m_t[i] = 0;
                        else begin m_acc[i] = 0; m_nout[i] = 1'b0; end
                    end
                end
                if (take) begin
                    m_smode[i] = cfg_if.cfg_mode; m_scode[i] = int'(cfg_if.cfg_code); m_pend[i] = 1'b1;
                end
            end
        end
    end

    // Compare DUT to the model on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [CH-1:0] e_out, e_pend;
            for (int i = 0; i < CH; i++) begin
                e_out[i]  = m_out(i);
                e_pend[i] = m_pend[i];
            end
            check("model_dco_out", int'(dco_out), int'(e_out));
            check("model_pending", int'(pending), int'(e_pend));
            check("model_cfg_ready", int'(cfg_if.cfg_ready), int'(!m_pend[cfg_if.cfg_ch]));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and hold valid until accepted; ends at posedge+1 of the accept edge.
    task automatic cfg_write(input int ch, input bit mode, input int code, output int stall);
        bit rdy = 1'b0;
        int n = 0;
        stall = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_mode  = dco_mode_e'(mode);
        cfg_if.cfg_code  = CW'(code);
        while (!rdy && n < 2000) begin
            @(negedge clk);
            rdy = cfg_if.cfg_ready;
            align();
            if (!rdy) stall++;
            n++;
        end
        cfg_if.cfg_valid = 1'b0;
        check("cfg_write_accepted", int'(rdy), 1);
    endtask

    // Measure period and high time of one output from its next rising edge.
    task automatic measure(input int ch, input int exp_p, input int exp_h, input string name);
        bit prev, cur, found;
        int n, p, h;
        @(negedge clk);
        prev = dco_out[ch]; found = 1'b0; n = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            cur = dco_out[ch];
            if (cur && !prev) found = 1'b1;
            prev = cur;
            n++;
        end
        if (!found) begin
            check({name, "_rise_timeout"}, 0, 1);
        end else begin
            p = 1; h = 1; found = 1'b0; n = 0;
            while (!found && n < 2000) begin
                @(negedge clk);
                cur = dco_out[ch];
                if (cur && !prev) found = 1'b1;
                else begin
                    if (cur) h++;
                    p++;
                end
                prev = cur;
                n++;
            end
            check({name, "_period"}, p, exp_p);
            check({name, "_high"}, h, exp_h);
        end
        align();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int stall;
        int n;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_mode  = DCO_DIV;
        cfg_if.cfg_code  = '0;

        // Reset state and first rise at edge 2, period 4 on all channels.
        repeat (3) @(posedge clk);
        #1;
        check("reset_dco_out", int'(dco_out), 0);
        check("reset_pending", int'(pending), 0);
        rst_n = 1'b1;
        @(negedge clk); check("edge0_out", int'(dco_out), 0);
        @(negedge clk); check("edge1_out", int'(dco_out), 0);
        @(negedge clk); check("edge2_out", int'(dco_out), 4'hF);
        align();
        measure(0, 4, 2, "ch0_reset");

        // ch1 DIV code 4: pending until the rising toggle, then period 10.
        repeat (1) align();
        cfg_write(1, 1'b0, 4, stall);
        @(negedge clk); check("ch1_pending_after_write", int'(pending[1]), 1);
        align();
        measure(1, 10, 5, "ch1_div4");
        measure(0, 4, 2, "ch0_unaffected");

        // Back-to-back writes to ch1: the second stalls until the boundary.
        cfg_write(1, 1'b0, 4, stall);
        cfg_write(1, 1'b0, 3, stall);
        check("ch1_second_write_stalled", int'(stall > 0), 1);
        measure(1, 8, 4, "ch1_div3");

        // ch2 NCO 0x80 -> period 512; then NCO 0 freezes; then DIV 2 applies next cycle.
        cfg_write(2, 1'b1, 8'h80, stall);
        measure(2, 512, 256, "ch2_nco80");
        cfg_write(2, 1'b1, 0, stall);
        n = 0;
        do begin @(negedge clk); n++; end while (pending[2] && n < 1000);
        check("ch2_nco0_applied", int'(pending[2]), 0);
        for (int k = 0; k < 5; k++) begin
            repeat (10) @(negedge clk);
            check("ch2_frozen_out", int'(dco_out[2]), 0);
        end
        align();
        cfg_write(2, 1'b0, 2, stall);
        @(negedge clk); check("ch2_div2_pending", int'(pending[2]), 1);
        @(negedge clk);
        check("ch2_div2_applied", int'(pending[2]), 0);
        check("ch2_div2_rise", int'(dco_out[2]), 1);
        align();
        measure(2, 6, 3, "ch2_div2");

        // ena low for 20 cycles with a write to ch3; model checks hold and resume.
        ena = 1'b0;
        cfg_write(3, 1'b0, 5, stall);
        repeat (20) align();
        check("ch3_pending_while_frozen", int'(pending[3]), 1);
        ena = 1'b1;
        repeat (40) align();

        // sync with all channels pending: clears pendings, all low, equal codes rise together.
        ena = 1'b0;
        for (int i = 0; i < CH; i++) cfg_write(i, 1'b0, 2, stall);
        check("all_pending_before_sync", int'(pending), 4'hF);
        sync = 1'b1;
        align();
        sync = 1'b0;
        ena  = 1'b1;
        @(negedge clk);
        check("sync_pending_clear", int'(pending), 0);
        check("sync_out_low", int'(dco_out), 0);
        @(negedge clk); check("sync_e1_out", int'(dco_out), 0);
        @(negedge clk); check("sync_e2_out", int'(dco_out), 0);
        @(negedge clk); check("sync_e3_out", int'(dco_out), 4'hF);
        align();
        measure(3, 6, 3, "ch3_after_sync");

        // Asynchronous reset mid-period, away from any clock edge.
        align();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", int'(dco_out), 0);
        check("async_reset_pending", int'(pending), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
